gate_truth_table_checker: RTL and testbench

Self-running stimulus-and-check stage for the team's basic gate library. On a start pulse it drives every input vector of a gate under test, waits a fixed settle time, samples the gate output and compares it with a built-in reference for the selected logic function. It reports a pass/fail verdict, mismatch count and first failing vector. It sits directly around a gate block: upstream as its stimulus source, downstream as the consumer of its output.

---
 rtl/gate_check_pkg.sv | 48 ++++
 rtl/gate_truth_table_checker_if.sv | 26 ++
 rtl/gate_ref_model.sv | 21 ++
 rtl/gate_truth_table_checker.sv | 154 +++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table checker: op encoding, FSM states,
// and the reference logic function used by the checker and gate testbenches.
package gate_check_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_DONE   = 3'd3,
      ST_REJECT = 3'd4
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_XNOR);
   endfunction

   // Inputs above num_in are masked so the reductions only see real gate pins.
   function automatic logic gate_expected(input logic [2:0] op, input logic [3:0] vec,
                                          input int num_in);
      logic [3:0] mask;
      logic       red_and;
      logic       red_or;
      logic       red_xor;
      for (int i = 0; i < 4; i++) begin
         mask[i] = (i < num_in);
      end
      red_and = &(vec | ~mask);
      red_or  = |(vec & mask);
      red_xor = ^(vec & mask);
      case (op)
         OP_AND:  gate_expected = red_and;
         OP_OR:   gate_expected = red_or;
         OP_NAND: gate_expected = ~red_and;
         OP_NOR:  gate_expected = ~red_or;
         OP_XOR:  gate_expected = red_xor;
         OP_XNOR: gate_expected = ~red_xor;
         default: gate_expected = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Stimulus/result bundle between the checker and the gate under test plus its controller.
interface gate_truth_table_checker_if #(
   parameter int NUM_IN = 2
);
   logic              start;
   logic [2:0]        op_sel;
   logic [NUM_IN-1:0] dut_in;
   logic              dut_y;
   logic              busy;
   logic              done;
   logic              pass;
   logic [NUM_IN:0]   err_count;
   logic [NUM_IN-1:0] first_fail_vec;
   logic              fail_valid;
   logic              bad_op;

   modport master (
      output start, op_sel, dut_y,
      input  dut_in, busy, done, pass, err_count, first_fail_vec, fail_valid, bad_op
   );

   modport slave (
      input  start, op_sel, dut_y,
      output dut_in, busy, done, pass, err_count, first_fail_vec, fail_valid, bad_op
   );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference gate: expected output for (op, vector) over NUM_IN inputs.
module gate_ref_model
   import gate_check_pkg::*;
#(
   parameter int NUM_IN = 2
) (
   input  logic [2:0]        op,
   input  logic [NUM_IN-1:0] vec,
   output logic              expected
);

   logic [3:0] vec_ext;

   // Widen the vector to the package function's 4-bit form and evaluate it.
   always_comb begin
      vec_ext               = 4'd0;
      vec_ext[NUM_IN-1:0]   = vec;
      expected              = gate_expected(op, vec_ext, NUM_IN);
   end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Self-running exhaustive stimulus and check stage around a single gate under test:
// walks every input vector, samples the gate after settling, and tallies mismatches.
module gate_truth_table_checker
   import gate_check_pkg::*;
#(
   parameter int NUM_IN        = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input logic                      clk,
   input logic                      rst,
   gate_truth_table_checker_if.slave bus
);

   localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
   localparam state_t     AFTER_VEC   = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
   localparam logic [NUM_IN-1:0] LAST_VEC = '1;

   state_t            state_r;
   state_t            state_nx;
   logic [2:0]        op_r;
   logic [NUM_IN-1:0] dut_in_r;
   logic [3:0]        cnt_r;
   logic              busy_r;
   logic              done_r;
   logic              pass_r;
   logic [NUM_IN:0]   err_r;
   logic [NUM_IN-1:0] ffv_r;
   logic              fv_r;
   logic              bad_op_r;
   logic              expected_s;
   logic              mismatch_s;

   gate_ref_model #(.NUM_IN(NUM_IN)) u_ref (
      .op       (op_r),
      .vec      (dut_in_r),
      .expected (expected_s)
   );

   assign mismatch_s = bus.dut_y ^ expected_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nx = op_legal(bus.op_sel) ? AFTER_VEC : ST_REJECT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
               state_nx = ST_CHECK;
            end else begin
               state_nx = ST_SETTLE;
            end
         end
         ST_CHECK: begin
            if (dut_in_r == LAST_VEC) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = AFTER_VEC;
            end
         end
         ST_DONE:   state_nx = ST_IDLE;
         ST_REJECT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Vector, settle counter and result registers; all outputs come straight from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= 3'd0;
         dut_in_r <= '0;
         cnt_r    <= 4'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
         err_r    <= '0;
         ffv_r    <= '0;
         fv_r     <= 1'b0;
         bad_op_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r  <= 4'd0;
               done_r <= 1'b0;
               if (bus.start) begin
                  op_r     <= bus.op_sel;
                  dut_in_r <= '0;
                  pass_r   <= 1'b0;
                  err_r    <= '0;
                  ffv_r    <= '0;
                  fv_r     <= 1'b0;
                  bad_op_r <= ~op_legal(bus.op_sel);
                  busy_r   <= op_legal(bus.op_sel);
                  done_r   <= ~op_legal(bus.op_sel);
               end
            end
            ST_SETTLE: begin
               cnt_r <= (cnt_r == SETTLE_LAST) ? 4'd0 : cnt_r + 4'd1;
            end
            ST_CHECK: begin
               if (mismatch_s) begin
                  err_r <= err_r + (NUM_IN + 1)'(1'b1);
                  if (!fv_r) begin
                     ffv_r <= dut_in_r;
                     fv_r  <= 1'b1;
                  end
               end
               if (dut_in_r == LAST_VEC) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  pass_r <= ~mismatch_s & (err_r == '0);
               end else begin
                  dut_in_r <= dut_in_r + NUM_IN'(1'b1);
               end
            end
            ST_DONE: begin
               done_r   <= 1'b0;
               dut_in_r <= '0;
            end
            ST_REJECT: begin
               done_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dut_in         = dut_in_r;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.pass           = pass_r;
   assign bus.err_count      = err_r;
   assign bus.first_fail_vec = ffv_r;
   assign bus.fail_valid     = fv_r;
   assign bus.bad_op         = bad_op_r;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomized bench for gate_truth_table_checker: three configurations driven against a
// popcount-based model of the gate functions and of the run schedule.
module tb_gate_truth_table_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic       start_v [3];
   logic [2:0] op_v    [3];
   logic [2:0] kind_v  [3];
   logic [3:0] obs_in  [3];
   logic [4:0] obs_err [3];
   logic [3:0] obs_ffv [3];
   logic [4:0] obs_flg [3];   // {busy, done, pass, fail_valid, bad_op}

   int cfg_n [3] = '{2, 2, 3};
   int cfg_s [3] = '{2, 0, 1};

   // Gate function by popcount; kinds 6/7 model outputs tied low/high.
   function automatic logic ref_out(input int op, input int vec, input int n);
      int ones;
      ones = $countones(vec);
      case (op)
         0: return ones == n;
         1: return ones > 0;
         2: return ones != n;
         3: return ones == 0;
         4: return (ones % 2) == 1;
         5: return (ones % 2) == 0;
         6: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   gate_truth_table_checker_if #(.NUM_IN(2)) if_a ();
   gate_truth_table_checker_if #(.NUM_IN(2)) if_b ();
   gate_truth_table_checker_if #(.NUM_IN(3)) if_c ();

   gate_truth_table_checker #(.NUM_IN(2), .SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   gate_truth_table_checker #(.NUM_IN(2), .SETTLE_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   gate_truth_table_checker #(.NUM_IN(3), .SETTLE_CYCLES(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   assign if_a.start  = start_v[0];
   assign if_a.op_sel = op_v[0];
   assign if_a.dut_y  = ref_out(int'(kind_v[0]), int'(obs_in[0]), 2);
   assign obs_in[0]   = 4'(if_a.dut_in);
   assign obs_err[0]  = 5'(if_a.err_count);
   assign obs_ffv[0]  = 4'(if_a.first_fail_vec);
   assign obs_flg[0]  = {if_a.busy, if_a.done, if_a.pass, if_a.fail_valid, if_a.bad_op};

   assign if_b.start  = start_v[1];
   assign if_b.op_sel = op_v[1];
   assign if_b.dut_y  = ref_out(int'(kind_v[1]), int'(obs_in[1]), 2);
   assign obs_in[1]   = 4'(if_b.dut_in);
   assign obs_err[1]  = 5'(if_b.err_count);
   assign obs_ffv[1]  = 4'(if_b.first_fail_vec);
   assign obs_flg[1]  = {if_b.busy, if_b.done, if_b.pass, if_b.fail_valid, if_b.bad_op};

   assign if_c.start  = start_v[2];
   assign if_c.op_sel = op_v[2];
   assign if_c.dut_y  = ref_out(int'(kind_v[2]), int'(obs_in[2]), 3);
   assign obs_in[2]   = 4'(if_c.dut_in);
   assign obs_err[2]  = 5'(if_c.err_count);
   assign obs_ffv[2]  = 4'(if_c.first_fail_vec);
   assign obs_flg[2]  = {if_c.busy, if_c.done, if_c.pass, if_c.fail_valid, if_c.bad_op};

   // One complete run on instance idx; poke sprinkles ignored start pulses while busy.
   task automatic run_one(input int idx, input int op, input int kind, input bit poke);
      int  n, s, nv, total, exp_err, exp_first;
      bit  legal;
      n = cfg_n[idx];
      s = cfg_s[idx];
      nv = 1 << n;
      total = nv * (s + 1);
      legal = (op <= 5);
      exp_err = 0;
      exp_first = 0;
      if (legal) begin
         for (int k = 0; k < nv; k++) begin
            if (ref_out(kind, k, n) != ref_out(op, k, n)) begin
               if (exp_err == 0) exp_first = k;
               exp_err++;
            end
         end
      end
      @(negedge clk);
      start_v[idx] = 1'b1;
      op_v[idx]    = 3'(op);
      kind_v[idx]  = 3'(kind);
      @(posedge clk);
      #1;
      start_v[idx] = 1'b0;
      op_v[idx]    = 3'($urandom);
      if (!legal) begin
         check("rej_flags", 32'(obs_flg[idx]), 32'(5'b01001));
         check("rej_in",    32'(obs_in[idx]),  32'd0);
         check("rej_err",   32'(obs_err[idx]), 32'd0);
         @(posedge clk);
         #1;
         check("rej_after", 32'(obs_flg[idx]), 32'(5'b00001));
      end else begin
         for (int c = 0; c < total; c++) begin
            check("trace", 32'({obs_flg[idx][4:3], obs_in[idx]}), 32'({2'b10, 4'(c / (s + 1))}));
            if (poke) start_v[idx] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         start_v[idx] = 1'b0;
         check("done_flags", 32'(obs_flg[idx]),
               32'({1'b0, 1'b1, 1'(exp_err == 0), 1'(exp_err != 0), 1'b0}));
         check("done_err",   32'(obs_err[idx]), 32'(exp_err));
         check("done_ffv",   32'(obs_ffv[idx]), 32'(exp_first));
         @(posedge clk);
         #1;
         check("idle_flags", 32'(obs_flg[idx]),
               32'({2'b00, 1'(exp_err == 0), 1'(exp_err != 0), 1'b0}));
         check("idle_in",    32'(obs_in[idx]),  32'd0);
         check("idle_err",   32'(obs_err[idx]), 32'(exp_err));
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int  waited;
      bit  saw_done;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         op_v[i]    = 3'd0;
         kind_v[i]  = 3'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset", 32'({obs_flg[i], obs_in[i], obs_err[i], obs_ffv[i]}), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_one(0, 0, 0, 1'b0);   // AND gate, AND reference
      run_one(0, 1, 0, 1'b1);   // AND gate, OR reference: 2 errors, first 01
      run_one(0, 6, 0, 1'b0);   // reserved op
      run_one(1, 4, 6, 1'b0);   // no settle, XOR vs tied-low output
      run_one(2, 2, 2, 1'b1);   // 3-input NAND

      // Reset in the middle of a run while vector 10 is on the gate.
      @(negedge clk);
      start_v[0] = 1'b1;
      op_v[0]    = 3'd0;
      kind_v[0]  = 3'd0;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      waited = 0;
      while (obs_in[0] != 4'd2 && waited < 40) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("rst_reach", 32'(waited < 40), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid", 32'({obs_flg[0], obs_in[0], obs_err[0], obs_ffv[0]}), 32'd0);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (obs_flg[0][3]) saw_done = 1'b1;
      end
      check("rst_nodone", 32'(saw_done), 32'd0);
      run_one(0, 5, 4, 1'b0);   // XOR gate, XNOR reference: every vector fails

      repeat (30) begin
         run_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
